// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson phase counter with load, wrap pulse and illegal-state flag.
// Optional: RING_COUNTER_GEN_SELF_CORRECT_EN forces an illegal state back to start on an enabled cycle.
module ring_counter_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("ring_counter_gen: WIDTH must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] start_new;
    logic [WIDTH-1:0] start_cur;
    logic [WIDTH-1:0] shift_val;
    logic             feedback;
    logic             mode_chg;
    logic [WIDTH-2:0] edges;
    logic             ring_err;
    logic             john_err;

    always_comb begin
        start_new = mode   ? '0 : WIDTH'(1);
        start_cur = mode_q ? '0 : WIDTH'(1);
        mode_chg  = (mode != mode_q);
    end

    // Johnson differs from ring only by inverting the bit fed back in.
    always_comb begin
        feedback  = 1'b0;
        shift_val = q_q;
        if (dir) begin
            feedback  = mode_q ? ~q_q[0] : q_q[0];
            shift_val = {feedback, q_q[WIDTH-1:1]};
        end else begin
            feedback  = mode_q ? ~q_q[WIDTH-1] : q_q[WIDTH-1];
            shift_val = {q_q[WIDTH-2:0], feedback};
        end
    end

    always_comb begin
        edges    = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
        ring_err = (q_q == '0) ||
                   ((q_q & (q_q - WIDTH'(1))) != '0);
        john_err = ((edges & (edges - (WIDTH-1)'(1))) != '0);
        err      = mode_q ? john_err : ring_err;
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        mode_d = mode;
        if (load) begin
            q_d = load_val;
        end else if (mode_chg) begin
            q_d = start_new;
        end else if (en) begin
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
            if (err) begin
                q_d = start_cur;
            end else begin
                q_d    = shift_val;
                wrap_d = (shift_val == start_cur);
            end
`else
            q_d    = shift_val;
            wrap_d = (shift_val == start_cur);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= WIDTH'(1);
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Self-checking bench for ring_counter_gen: directed scenarios plus randomized run
// against a behavioural model (WIDTH=4 main instance, WIDTH=2 side instance).
module tb_ring_counter_gen;

    localparam int W = 4;
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         wrap, err;

    logic         en2 = 1'b0, mode2 = 1'b0, dir2 = 1'b0, load2 = 1'b0;
    logic [1:0]   load_val2 = '0;
    logic [1:0]   q2;
    logic         wrap2, err2;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_q;
    logic         m_mode, m_wrap;

    always #5 clk = ~clk;

    ring_counter_gen #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .q(q), .wrap(wrap), .err(err)
    );

    ring_counter_gen #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .dir(dir2),
        .load(load2), .load_val(load_val2),
        .q(q2), .wrap(wrap2), .err(err2)
    );

    function automatic logic [W-1:0] start_of(input logic md);
        return md ? '0 : W'(1);
    endfunction

    function automatic logic model_err(input logic [W-1:0] v, input logic md);
        logic [W-1:0] msk;
        msk = {W{1'b1}} >> 1;
        if (!md) return ($countones(v) != 1);
        return ($countones((v ^ (v >> 1)) & msk) > 1);
    endfunction

    // Advance one clock edge and move the model by the same rules.
    task automatic step();
        logic [W-1:0] nq;
        logic         nw, top;
        @(posedge clk);
        nw = 1'b0;
        nq = m_q;
        if (load) begin
            nq = load_val;
        end else if (mode != m_mode) begin
            nq = start_of(mode);
        end else if (en) begin
            if (SC && model_err(m_q, m_mode)) begin
                nq = start_of(m_mode);
            end else begin
                if (dir) begin
                    top = m_q[0] ^ m_mode;
                    nq  = (m_q >> 1) + (top ? W'(1 << (W-1)) : W'(0));
                end else begin
                    top = m_q[W-1] ^ m_mode;
                    nq  = W'(m_q * 2) + W'(top);
                end
                nw = (nq == start_of(m_mode));
            end
        end
        m_q    = nq;
        m_wrap = nw;
        m_mode = mode;
        #1;
    endtask

    task automatic do_reset();
        en = 0; load = 0; mode = 0; dir = 0; en2 = 0;
        rst = 1;
        #2;
        m_q = W'(1); m_mode = 0; m_wrap = 0;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        checks++;
        if (q !== 4'b0001) begin failures++; $display("FAIL reset_q got=%b exp=0001", q); end
        checks++;
        if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        do_reset();
    endtask

    task automatic test_ring();
        logic [W-1:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (q !== exp_q[i] || wrap !== (i == 3) || err !== 1'b0) begin
                failures++;
                $display("FAIL ring_seq i=%0d got q=%b w=%b e=%b exp q=%b w=%b e=0",
                         i, q, wrap, err, exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_johnson();
        logic [W-1:0] up [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        logic [W-1:0] dn [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
        do_reset();
        mode = 1; en = 1;
        step();
        checks++;
        if (q !== 4'h0 || wrap !== 1'b0) begin
            failures++; $display("FAIL john_enter got q=%b w=%b exp q=0000 w=0", q, wrap);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (q !== up[i] || wrap !== (i == 7) || err !== 1'b0) begin
                failures++;
                $display("FAIL john_up i=%0d got q=%b w=%b e=%b exp q=%b w=%b",
                         i, q, wrap, err, up[i], (i == 7));
            end
        end
        dir = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (q !== dn[i] || wrap !== (i == 7) || err !== 1'b0) begin
                failures++;
                $display("FAIL john_dn i=%0d got q=%b w=%b e=%b exp q=%b w=%b",
                         i, q, wrap, err, dn[i], (i == 7));
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        load = 1; load_val = 4'b0110;
        step();
        load = 0;
        checks++;
        if (q !== 4'b0110 || err !== 1'b1 || wrap !== 1'b0) begin
            failures++; $display("FAIL illegal_load got q=%b e=%b w=%b exp q=0110 e=1 w=0", q, err, wrap);
        end
        en = 1;
        step();
        checks++;
        if (SC) begin
            if (q !== 4'b0001 || err !== 1'b0 || wrap !== 1'b0) begin
                failures++; $display("FAIL illegal_fix got q=%b e=%b w=%b exp q=0001 e=0 w=0", q, err, wrap);
            end
        end else begin
            if (q !== 4'b1100 || err !== 1'b1 || wrap !== 1'b0) begin
                failures++; $display("FAIL illegal_sh1 got q=%b e=%b w=%b exp q=1100 e=1 w=0", q, err, wrap);
            end
        end
        step();
        checks++;
        if (SC) begin
            if (q !== 4'b0010 || err !== 1'b0) begin
                failures++; $display("FAIL illegal_fix2 got q=%b e=%b exp q=0010 e=0", q, err);
            end
        end else begin
            if (q !== 4'b1001 || err !== 1'b1) begin
                failures++; $display("FAIL illegal_sh2 got q=%b e=%b exp q=1001 e=1", q, err);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        en = 1;
        step(); step();
        checks++;
        if (q !== 4'b0100) begin failures++; $display("FAIL msw_pre got=%b exp=0100", q); end
        mode = 1;
        step();
        checks++;
        if (q !== 4'b0000 || wrap !== 1'b0) begin
            failures++; $display("FAIL msw_switch got q=%b w=%b exp q=0000 w=0", q, wrap);
        end
        step();
        checks++;
        if (q !== 4'b0001) begin failures++; $display("FAIL msw_j1 got=%b exp=0001", q); end
        step();
        checks++;
        if (q !== 4'b0011) begin failures++; $display("FAIL msw_j2 got=%b exp=0011", q); end
    endtask

    task automatic test_load_priority();
        do_reset();
        load = 1; en = 1; mode = 1; load_val = 4'b0011;
        step();
        load = 0; en = 0;
        checks++;
        if (q !== 4'b0011 || err !== 1'b0 || wrap !== 1'b0) begin
            failures++; $display("FAIL load_prio got q=%b e=%b w=%b exp q=0011 e=0 w=0", q, err, wrap);
        end
        step();
        checks++;
        if (q !== 4'b0011) begin failures++; $display("FAIL load_hold got=%b exp=0011", q); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1;
        step(); step(); step();
        checks++;
        if (q !== 4'b1000) begin failures++; $display("FAIL arst_pre got=%b exp=1000", q); end
        rst = 1;
        #2;
        checks++;
        if (q !== 4'b0001 || wrap !== 1'b0) begin
            failures++; $display("FAIL arst_now got q=%b w=%b exp q=0001 w=0", q, wrap);
        end
        do_reset();
    endtask

    task automatic test_hold();
        do_reset();
        en = 1;
        step(); step();
        en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (q !== 4'b0100 || wrap !== 1'b0) begin
                failures++; $display("FAIL hold i=%0d got q=%b w=%b exp q=0100 w=0", i, q, wrap);
            end
        end
    endtask

    task automatic test_width2();
        logic [1:0] exp2;
        do_reset();
        en2 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp2 = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if (q2 !== exp2 || wrap2 !== (exp2 == 2'b01) || err2 !== 1'b0) begin
                failures++;
                $display("FAIL w2_ring i=%0d got q=%b w=%b e=%b exp q=%b w=%b",
                         i, q2, wrap2, err2, exp2, (exp2 == 2'b01));
            end
        end
        en2 = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(3, 0) != 0);
            dir      = $urandom_range(1, 0);
            load     = ($urandom_range(19, 0) == 0);
            load_val = W'($urandom);
            if ($urandom_range(11, 0) == 0) mode = ~mode;
            step();
            checks++;
            if (q !== m_q || wrap !== m_wrap || err !== model_err(m_q, m_mode)) begin
                failures++;
                $display("FAIL rand i=%0d got q=%b w=%b e=%b exp q=%b w=%b e=%b",
                         i, q, wrap, err, m_q, m_wrap, model_err(m_q, m_mode));
            end
        end
        load = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_johnson();
        test_illegal();
        test_mode_switch();
        test_load_priority();
        test_async_reset();
        test_hold();
        test_width2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
